// File: rtl/linebuffer_loader_if.sv
// ---------------------------------------------------------------------------
// linebuffer_loader_if
//   Bundles the pixel-stream handshake, the line-buffer write bus and the
//   convolver control/status lines of the line-buffer loader.
//
//   Signals
//     start        : begin a frame (environment -> loader)
//     pix_valid    : upstream pixel beat valid
//     pix_data     : upstream pixel, raster order
//     pix_ready    : loader can accept a beat
//     wr_en        : line-buffer write strobe
//     wr_row       : physical slot written, 0..2
//     wr_col       : column written, 0..COLS-1
//     wr_data      : pixel written
//     window_valid : three rows resident in the line buffer
//     top_row      : physical slot holding the oldest image row
//     row_consumed : convolver no longer needs the top row
//     frame_done   : one-cycle end-of-frame pulse
//
//   Modports
//     master : environment side (drives stream and control)
//     slave  : loader side
// ---------------------------------------------------------------------------
interface linebuffer_loader_if #(
    parameter int BIT_DEPTH = 8,
    parameter int COLS      = 28
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic                 start;
    logic                 pix_valid;
    logic [BIT_DEPTH-1:0] pix_data;
    logic                 pix_ready;
    logic                 wr_en;
    logic [1:0]           wr_row;
    logic [CW-1:0]        wr_col;
    logic [BIT_DEPTH-1:0] wr_data;
    logic                 window_valid;
    logic [1:0]           top_row;
    logic                 row_consumed;
    logic                 frame_done;

    modport master (
        output start, pix_valid, pix_data, row_consumed,
        input  pix_ready, wr_en, wr_row, wr_col, wr_data,
               window_valid, top_row, frame_done
    );

    modport slave (
        input  start, pix_valid, pix_data, row_consumed,
        output pix_ready, wr_en, wr_row, wr_col, wr_data,
               window_valid, top_row, frame_done
    );
endinterface

// File: rtl/linebuffer_loader.sv
// ---------------------------------------------------------------------------
// linebuffer_loader
//   Write-side feeder for a 3-row convolution line buffer. Loads a raster
//   pixel stream into three physical row slots, raises window_valid once
//   three rows are resident, refills the oldest slot whenever the convolver
//   releases the top row, and pulses frame_done after ROWS rows have been
//   loaded and the last window consumed.
//
//   Ports
//     clk : clock, rising edge
//     rst : asynchronous active-high reset
//     lb  : linebuffer_loader_if.slave (stream, write bus, control/status)
// ---------------------------------------------------------------------------
module linebuffer_loader #(
    parameter int BIT_DEPTH = 8,
    parameter int COLS      = 28,
    parameter int ROWS      = 28
) (
    input  logic               clk,
    input  logic               rst,
    linebuffer_loader_if.slave lb
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = $clog2(ROWS + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_ALL  = RW'(ROWS);
    localparam logic [RW-1:0] ROW_3RD  = RW'(2);

    typedef enum logic [2:0] {IDLE, FILL, READY, REFILL, FLUSH, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        col_q, col_d;
    logic [1:0]           slot_q, slot_d;
    logic [RW-1:0]        rows_q, rows_d;
    logic [1:0]           top_q, top_d;

    logic                 pix_ready_q;
    logic                 wr_en_q;
    logic [1:0]           wr_row_q;
    logic [CW-1:0]        wr_col_q;
    logic [BIT_DEPTH-1:0] wr_data_q;
    logic                 window_valid_q;
    logic                 frame_done_q;

    logic                 accept;
    logic                 row_wrap;
    logic [1:0]           wr_slot;

    assign accept   = lb.pix_valid & pix_ready_q;
    assign row_wrap = accept && (col_q == COL_LAST);
    // Refills overwrite the oldest row; the initial fill walks the slots.
    assign wr_slot  = (state_q == REFILL) ? top_q : slot_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        slot_d  = slot_q;
        rows_d  = rows_q;
        top_d   = top_q;

        if (accept) begin
            col_d = row_wrap ? '0 : col_q + 1'b1;
            if (row_wrap) begin
                rows_d = rows_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (lb.start) begin
                    state_d = FILL;
                    col_d   = '0;
                    slot_d  = '0;
                    rows_d  = '0;
                    top_d   = '0;
                end
            end
            FILL: begin
                if (row_wrap) begin
                    slot_d = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
                    if (rows_q == ROW_3RD) begin
                        state_d = FLUSH;
                    end
                end
            end
            REFILL: begin
                if (row_wrap) begin
                    top_d   = (top_q == 2'd2) ? 2'd0 : top_q + 2'd1;
                    state_d = FLUSH;
                end
            end
            // One idle cycle so the final row write retires before the window opens.
            FLUSH: state_d = READY;
            READY: begin
                if (lb.row_consumed) begin
                    state_d = (rows_q == ROW_ALL) ? DONE : REFILL;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q          <= '0;
            slot_q         <= '0;
            rows_q         <= '0;
            top_q          <= '0;
            pix_ready_q    <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_row_q       <= '0;
            wr_col_q       <= '0;
            wr_data_q      <= '0;
            window_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            col_q        <= col_d;
            slot_q       <= slot_d;
            rows_q       <= rows_d;
            top_q        <= top_d;
            pix_ready_q  <= (state_d == FILL) || (state_d == REFILL);
            wr_en_q      <= accept;
            if (accept) begin
                wr_row_q  <= wr_slot;
                wr_col_q  <= col_q;
                wr_data_q <= lb.pix_data;
            end
            // Window opens on the second READY cycle and closes on the edge
            // that leaves READY.
            window_valid_q <= (state_q == READY) && (state_d == READY);
            frame_done_q   <= (state_d == DONE);
        end
    end

    assign lb.pix_ready    = pix_ready_q;
    assign lb.wr_en        = wr_en_q;
    assign lb.wr_row       = wr_row_q;
    assign lb.wr_col       = wr_col_q;
    assign lb.wr_data      = wr_data_q;
    assign lb.window_valid = window_valid_q;
    assign lb.top_row      = top_q;
    assign lb.frame_done   = frame_done_q;
endmodule

// File: tb/tb_linebuffer_loader.sv
module tb_linebuffer_loader;
    logic clk;
    logic rst;

    linebuffer_loader_if #(.BIT_DEPTH(8), .COLS(4)) lb ();

    linebuffer_loader #(.BIT_DEPTH(8), .COLS(4), .ROWS(5)) dut (
        .clk (clk),
        .rst (rst),
        .lb  (lb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       pv;
        logic       rc;
        logic [7:0] pd;
        logic       pr;
        logic       we;
        logic [1:0] wrow;
        logic [1:0] wcol;
        logic [7:0] wdata;
        logic       wv;
        logic [1:0] top;
        logic       fd;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic st, input logic pv, input logic rc, input logic [7:0] pd,
                       input logic pr, input logic we, input logic [1:0] wrow,
                       input logic [1:0] wcol, input logic [7:0] wdata, input logic wv,
                       input logic [1:0] top, input logic fd);
        vec_t v;
        v.st = st; v.pv = pv; v.rc = rc; v.pd = pd;
        v.pr = pr; v.we = we; v.wrow = wrow; v.wcol = wcol; v.wdata = wdata;
        v.wv = wv; v.top = top; v.fd = fd;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm, input int idx);
        chk({nm, ".pix_ready"},    idx, 32'(lb.pix_ready),    32'd0);
        chk({nm, ".wr_en"},        idx, 32'(lb.wr_en),        32'd0);
        chk({nm, ".wr_row"},       idx, 32'(lb.wr_row),       32'd0);
        chk({nm, ".wr_col"},       idx, 32'(lb.wr_col),       32'd0);
        chk({nm, ".wr_data"},      idx, 32'(lb.wr_data),      32'd0);
        chk({nm, ".window_valid"}, idx, 32'(lb.window_valid), 32'd0);
        chk({nm, ".top_row"},      idx, 32'(lb.top_row),      32'd0);
        chk({nm, ".frame_done"},   idx, 32'(lb.frame_done),   32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        lb.start = 1'b0; lb.pix_valid = 1'b0; lb.pix_data = 8'h00; lb.row_consumed = 1'b0;

        // ------------------------------------------------------------ table
        // Initial fill of a 4x5 frame.
        add(1, 0, 0, 8'h00, 1, 0, 2'd0, 2'd0, 8'h00, 0, 2'd0, 0);
        for (int i = 1; i <= 12; i++)  // row_consumed on beat 5 must be ignored
            add(0, 1, (i == 5), 8'(i), (i != 12), 1, 2'((i - 1) / 4), 2'((i - 1) % 4),
                8'(i), 0, 2'd0, 0);
        add(0, 0, 0, 8'h00, 0, 0, 2'd2, 2'd3, 8'h0C, 0, 2'd0, 0);   // FLUSH -> READY
        add(1, 0, 0, 8'h00, 0, 0, 2'd2, 2'd3, 8'h0C, 1, 2'd0, 0);   // window; start ignored
        // First refill into slot 0.
        add(0, 0, 1, 8'h00, 1, 0, 2'd2, 2'd3, 8'h0C, 0, 2'd0, 0);
        for (int i = 0; i < 4; i++)  // row_consumed on the second beat must be ignored
            add(0, 1, (i == 1), 8'(8'h10 + i), (i != 3), 1, 2'd0, 2'(i), 8'(8'h10 + i),
                0, (i == 3) ? 2'd1 : 2'd0, 0);
        add(0, 0, 0, 8'h00, 0, 0, 2'd0, 2'd3, 8'h13, 0, 2'd1, 0);
        add(0, 0, 0, 8'h00, 0, 0, 2'd0, 2'd3, 8'h13, 1, 2'd1, 0);
        // Second refill into slot 1.
        add(0, 0, 1, 8'h00, 1, 0, 2'd0, 2'd3, 8'h13, 0, 2'd1, 0);
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, 8'(8'h20 + i), (i != 3), 1, 2'd1, 2'(i), 8'(8'h20 + i),
                0, (i == 3) ? 2'd2 : 2'd1, 0);
        add(0, 0, 0, 8'h00, 0, 0, 2'd1, 2'd3, 8'h23, 0, 2'd2, 0);
        add(0, 0, 0, 8'h00, 0, 0, 2'd1, 2'd3, 8'h23, 1, 2'd2, 0);
        // All 5 rows loaded: final release ends the frame.
        add(0, 0, 1, 8'h00, 0, 0, 2'd1, 2'd3, 8'h23, 0, 2'd2, 1);  // DONE
        add(1, 0, 0, 8'h00, 0, 0, 2'd1, 2'd3, 8'h23, 0, 2'd2, 0);  // start in DONE ignored
        add(0, 0, 0, 8'h00, 0, 0, 2'd1, 2'd3, 8'h23, 0, 2'd2, 0);  // idle, no restart
        // New frame with a stalled stream: pix_valid 1,0,0,1.
        add(1, 0, 0, 8'h00, 1, 0, 2'd1, 2'd3, 8'h23, 0, 2'd0, 0);
        add(0, 1, 0, 8'hA1, 1, 1, 2'd0, 2'd0, 8'hA1, 0, 2'd0, 0);
        add(0, 0, 0, 8'hB2, 1, 0, 2'd0, 2'd0, 8'hA1, 0, 2'd0, 0);
        add(0, 0, 0, 8'hB2, 1, 0, 2'd0, 2'd0, 8'hA1, 0, 2'd0, 0);
        add(0, 1, 0, 8'hC3, 1, 1, 2'd0, 2'd1, 8'hC3, 0, 2'd0, 0);
        // Four more beats: six accepted so far in this frame.
        add(0, 1, 0, 8'hD1, 1, 1, 2'd0, 2'd2, 8'hD1, 0, 2'd0, 0);
        add(0, 1, 0, 8'hD2, 1, 1, 2'd0, 2'd3, 8'hD2, 0, 2'd0, 0);
        add(0, 1, 0, 8'hD3, 1, 1, 2'd1, 2'd0, 8'hD3, 0, 2'd0, 0);
        add(0, 1, 0, 8'hD4, 1, 1, 2'd1, 2'd1, 8'hD4, 0, 2'd0, 0);

        // ------------------------------------------------------------ reset state
        @(posedge clk); @(posedge clk); #1;
        chk_all_zero("reset", 0);
        rst = 1'b0;

        // ------------------------------------------------------------ vectors
        for (int i = 0; i < vq.size(); i++) begin
            lb.start        = vq[i].st;
            lb.pix_valid    = vq[i].pv;
            lb.pix_data     = vq[i].pd;
            lb.row_consumed = vq[i].rc;
            @(posedge clk); #1;
            chk("pix_ready",    i, 32'(lb.pix_ready),    32'(vq[i].pr));
            chk("wr_en",        i, 32'(lb.wr_en),        32'(vq[i].we));
            chk("wr_row",       i, 32'(lb.wr_row),       32'(vq[i].wrow));
            chk("wr_col",       i, 32'(lb.wr_col),       32'(vq[i].wcol));
            chk("wr_data",      i, 32'(lb.wr_data),      32'(vq[i].wdata));
            chk("window_valid", i, 32'(lb.window_valid), 32'(vq[i].wv));
            chk("top_row",      i, 32'(lb.top_row),      32'(vq[i].top));
            chk("frame_done",   i, 32'(lb.frame_done),   32'(vq[i].fd));
        end

        // ------------------------------------------------------------ async reset mid-fill
        lb.start = 1'b0; lb.row_consumed = 1'b0;
        lb.pix_valid = 1'b1; lb.pix_data = 8'hEE;
        #2 rst = 1'b1;
        #1;
        chk_all_zero("async_rst", 1);
        @(posedge clk); #1;
        chk("rst_hold.wr_en",     2, 32'(lb.wr_en),     32'd0);
        chk("rst_hold.pix_ready", 2, 32'(lb.pix_ready), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst.wr_en",     3 + i, 32'(lb.wr_en),     32'd0);
            chk("post_rst.pix_ready", 3 + i, 32'(lb.pix_ready), 32'd0);
            chk("post_rst.top_row",   3 + i, 32'(lb.top_row),   32'd0);
        end
        lb.pix_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
